i2s_transmit: RTL and testbench
===============================

# i2s_transmit

I2S transmitter for the playback path. It accepts stereo sample pairs from the fabric on a valid/ready handshake and buffers them in a small FIFO. It serializes each pair onto `AUD_DACDAT`, timed by the `AUD_BCLK` and `AUD_DACLRCK` clocks that the codec drives. It runs on the 50 MHz system clock, next to the microphone receive path and the codec config block.

## Interface
- `DATA_W`, 16: bits per channel word.
- `FIFO_DEPTH`, 4: number of sample pairs buffered; must be a power of two and at least 2.
- `CLK`  in  1  system clock (CLOCK_50).
- `RESET_N`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  the sample pair on `in_left`/`in_right` is valid.
- `in_ready`  out  1  the FIFO can accept a pair.
- `in_left`  in  DATA_W  left sample, two's complement.
- `in_right`  in  DATA_W  right sample, two's complement.
- `AUD_BCLK`  in  1  codec bit clock; asynchronous to `CLK`.
- `AUD_DACLRCK`  in  1  codec word select; low = left, high = right.
- `AUD_DACDAT`  out  1  serial data to the codec, registered.
- `underrun`  out  1  one-`CLK` pulse when a left frame starts with the FIFO empty.

## Operation
- **Synchronizers:** `AUD_BCLK` and `AUD_DACLRCK` each pass through two flops. A third BCLK flop provides falling-edge detection. The event `fall` is true for one `CLK` cycle per BCLK falling edge.
- **Work on `fall` only:** all serializer activity happens on `fall`. On each `fall`, the synchronized LRCK value `lr_s` is compared with the stored value `lr_prev`.
- **States:** the block has two states, `ST_SYNC` and `ST_RUN`. Reset enters `ST_SYNC`.
- **ST_SYNC:**
  - On each `fall`, store `lr_prev <= lr_s`.
  - When the stored value goes 1→0 (start of a left half-frame), move to `ST_RUN` and run the frame-start action in the same cycle.
  - `AUD_DACDAT` is held at 0 throughout `ST_SYNC`.
- **ST_RUN, on `fall`:**
  - **Frame start (`lr_s`=0, `lr_prev`=1):**
    - If the FIFO is not empty, pop it into the `hold_l`/`hold_r` registers.
    - If the FIFO is empty, pulse `underrun` and load the underrun value (see Configuration).
    - Load the shifter with the left word and set `bit_cnt <= DATA_W`.
    - Drive `AUD_DACDAT` to 0 for this slot. This is the I2S one-BCLK delay.
  - **Right start (`lr_s`=1, `lr_prev`=0):** load the shifter with `hold_r`, set `bit_cnt <= DATA_W`, and drive `AUD_DACDAT` to 0.
  - **No LRCK change, `bit_cnt` > 0:** drive `AUD_DACDAT <=` shifter MSB, shift left by one, and decrement `bit_cnt`.
  - **No LRCK change, `bit_cnt` = 0:** drive `AUD_DACDAT <= 0` (zero padding).
  - In every case, update `lr_prev <= lr_s`.
- **Short half-frame:** if LRCK toggles before `bit_cnt` reaches 0, the remaining bits are discarded and the new word loads normally.
- **FIFO:**
  - Pointers are `log2(FIFO_DEPTH)+1` bits wide; full and empty are decoded from the pointer MSBs.
  - `in_ready = !full`, combinational from registered pointers.
  - A push happens when `in_valid && in_ready`.
  - If a push and a pop occur in the same cycle while empty: the pop sees empty, so `underrun` fires and the pushed pair remains in the FIFO.
  - If a push and a pop occur in the same cycle while full: the push is blocked because `in_ready` is 0 that cycle.
- **Reset values:**
  - `AUD_DACDAT` = 0, `underrun` = 0, `in_ready` = 1.
  - FIFO is empty.
  - `bit_cnt`, the shifter and the hold registers are 0.
  - `lr_prev` = 1.
  - Reset asserted mid-word stops output immediately and returns the block to `ST_SYNC`.

## Timing
- **Output latency:** `AUD_DACDAT` changes 3 `CLK` cycles after the pin-level BCLK falling edge (two synchronizer stages plus the output register).
- **BCLK constraint:** BCLK high and low phases must each last at least 4 `CLK` periods. At 50 MHz this limits BCLK to 6.25 MHz or less; the standard 3.072 MHz is within limits.
- **Bit alignment:** the MSB is driven at the second BCLK falling edge after an LRCK transition and sampled by the codec on the following rising edge.
- **Input latency:** a pair pushed at least 1 `CLK` cycle before the frame-start `fall` is transmitted in that frame.
- **Steady-state throughput:** one pair per LRCK period.

## Configuration
- **`I2S_TX_REPEAT_EN` defined:** on underrun, `hold_l`/`hold_r` keep their previous contents, so the last pair is retransmitted.
- **`I2S_TX_REPEAT_EN` undefined:** on underrun, `hold_l`/`hold_r` are loaded with 0, producing silence.
- `underrun` pulses in both builds.

## Structure
- **Package `i2s_pkg`:**
  - the `DATA_W` default;
  - the state enum (`ST_SYNC`, `ST_RUN`);
  - the synchronizer depth localparam (2).
  - The receive path shares this package.
- **Sub-module `i2s_tx_fifo`:**
  - parameterized by width (`2*DATA_W`) and depth;
  - push/pop/full/empty ports;
  - asynchronous active-low reset.
- The serializer, synchronizers and FSM live in `i2s_transmit`.

## Test plan
- **Basic frame:** CLK = 50 MHz, BCLK = CLK/16, 32 BCLK per half-frame. Push L=16'hA5C3, R=16'h0F0F → after sync, `AUD_DACDAT` sequence per half-frame is a delay slot of 0, then A5C3 MSB-first, then 15 zeros; the right half-frame carries 0F0F the same way.
- **Underrun:** no push → one `underrun` pulse per frame, with output all zeros (macro undefined) or the repeated last pair (macro defined).
- **Backpressure:** `in_valid` held high with no BCLK running → `in_ready` drops after exactly `FIFO_DEPTH` (4) accepted pairs. Once BCLK runs, pairs are transmitted in push order 1..4.
- **Start-up:** release reset while LRCK is high mid-frame → `AUD_DACDAT` stays 0 until the first LRCK 1→0 transition, and the first transmitted word is the first pushed left sample.
- **Reset mid-operation:** assert `RESET_N`=0 mid-word → `AUD_DACDAT`=0 within the same `CLK` cycle, the FIFO is empty, and after release the block resynchronizes as in the start-up case.
- **Short half-frame:** 8 BCLK per half-frame with `DATA_W`=16 → the 7 MSBs of each word are transmitted, the rest are discarded, and the next word loads cleanly.

Source files
------------

// File: rtl/i2s_pkg.sv
`timescale 1ns/1ps
// i2s_pkg: shared definitions for the I2S transmit and receive paths.
package i2s_pkg;

  // Default bits per channel word.
  localparam int I2S_DATA_W = 16;

  // Number of flops used to bring codec clocks into the CLK domain.
  localparam int I2S_SYNC_STAGES = 2;

  // Serializer state: waiting for the first left half-frame, or running.
  typedef enum logic [0:0] {
    ST_SYNC = 1'b0,
    ST_RUN  = 1'b1
  } i2s_state_e;

endpackage

// File: rtl/i2s_tx_fifo.sv
`timescale 1ns/1ps
// i2s_tx_fifo: small synchronous FIFO holding packed {left, right} sample
// pairs. Pointers carry one extra wrap bit so full and empty can be told
// apart by the pointer MSBs. Pushes while full and pops while empty are
// ignored.
module i2s_tx_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             push_ok_s;
  logic             pop_ok_s;

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;
  assign pop_data  = mem_q[rd_ptr_q[AW-1:0]];

  // Next pointer and storage values for accepted pushes and pops.
  always_comb begin
    mem_d = mem_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Pointer and storage registers; reset leaves the FIFO empty and cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {(AW+1){1'b0}};
      rd_ptr_q <= {(AW+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/i2s_transmit.sv
`timescale 1ns/1ps
// i2s_transmit: I2S playback serializer. Sample pairs arrive on a
// valid/ready handshake, are buffered in i2s_tx_fifo, and are shifted out
// MSB-first on AUD_DACDAT with the standard one-BCLK delay after each LRCK
// edge. BCLK and LRCK are driven by the codec and synchronized into CLK;
// all serializer activity happens on the detected BCLK falling edge.
// Optional build macro: I2S_TX_REPEAT_EN -- when defined, an underrun
// retransmits the previous pair instead of sending silence.
module i2s_transmit
  import i2s_pkg::*;
#(
  parameter int DATA_W     = I2S_DATA_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_left,
  input  logic [DATA_W-1:0] in_right,
  input  logic              AUD_BCLK,
  input  logic              AUD_DACLRCK,
  output logic              AUD_DACDAT,
  output logic              underrun
);

  localparam int CW = $clog2(DATA_W + 1);
  localparam int SS = I2S_SYNC_STAGES;

  // Synchronizer chains and BCLK edge detector.
  logic [SS-1:0] bclk_sync_q, bclk_sync_d;
  logic [SS-1:0] lr_sync_q, lr_sync_d;
  logic          bclk_prev_q, bclk_prev_d;
  logic          bclk_s;
  logic          lr_s;
  logic          fall_s;

  // Serializer state.
  i2s_state_e        state_q, state_d;
  logic              lr_prev_q, lr_prev_d;
  logic [DATA_W-1:0] hold_l_q, hold_l_d;
  logic [DATA_W-1:0] hold_r_q, hold_r_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic              dac_q, dac_d;
  logic              underrun_q, underrun_d;

  // FIFO interface.
  logic                fifo_push_s;
  logic                fifo_pop_s;
  logic [2*DATA_W-1:0] fifo_rd_s;
  logic                fifo_full_s;
  logic                fifo_empty_s;

  // Frame-start words and the substitute used when the FIFO is empty.
  logic [DATA_W-1:0] uf_l_s, uf_r_s;
  logic [DATA_W-1:0] start_l_s, start_r_s;
  logic              frame_start_s;
  logic              right_start_s;

  i2s_tx_fifo #(
    .WIDTH (2*DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst_n     (RESET_N),
    .push      (fifo_push_s),
    .push_data ({in_left, in_right}),
    .pop       (fifo_pop_s),
    .pop_data  (fifo_rd_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  assign in_ready    = !fifo_full_s;
  assign fifo_push_s = in_valid && in_ready;
  assign AUD_DACDAT  = dac_q;
  assign underrun    = underrun_q;

  assign bclk_s        = bclk_sync_q[SS-1];
  assign lr_s          = lr_sync_q[SS-1];
  assign fall_s        = bclk_prev_q && !bclk_s;
  assign frame_start_s = fall_s && !lr_s && lr_prev_q;
  assign right_start_s = fall_s && lr_s && !lr_prev_q;

`ifdef I2S_TX_REPEAT_EN
  assign uf_l_s = hold_l_q;
  assign uf_r_s = hold_r_q;
`else
  assign uf_l_s = {DATA_W{1'b0}};
  assign uf_r_s = {DATA_W{1'b0}};
`endif

  // Shift the codec clocks through the synchronizer chains.
  always_comb begin
    bclk_sync_d = {bclk_sync_q[SS-2:0], AUD_BCLK};
    lr_sync_d   = {lr_sync_q[SS-2:0], AUD_DACLRCK};
    bclk_prev_d = bclk_s;
  end

  // Synchronizer and edge-detect flops; LRCK idles high so no false frame start.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      bclk_sync_q <= {SS{1'b0}};
      lr_sync_q   <= {SS{1'b1}};
      bclk_prev_q <= 1'b0;
    end else begin
      bclk_sync_q <= bclk_sync_d;
      lr_sync_q   <= lr_sync_d;
      bclk_prev_q <= bclk_prev_d;
    end
  end

  // Choose the pair for a new frame: FIFO head, or the underrun substitute.
  always_comb begin
    if (fifo_empty_s) begin
      start_l_s = uf_l_s;
      start_r_s = uf_r_s;
    end else begin
      start_l_s = fifo_rd_s[2*DATA_W-1:DATA_W];
      start_r_s = fifo_rd_s[DATA_W-1:0];
    end
  end

  // Next-state and serializer datapath, evaluated only on BCLK falls.
  always_comb begin
    state_d    = state_q;
    lr_prev_d  = lr_prev_q;
    hold_l_d   = hold_l_q;
    hold_r_d   = hold_r_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    dac_d      = dac_q;
    underrun_d = 1'b0;
    fifo_pop_s = 1'b0;
    if (fall_s) begin
      lr_prev_d = lr_s;
      if (frame_start_s) begin
        // Left half-frame begins in either state: fetch a pair, emit delay slot.
        state_d    = ST_RUN;
        fifo_pop_s = !fifo_empty_s;
        underrun_d = fifo_empty_s;
        hold_l_d   = start_l_s;
        hold_r_d   = start_r_s;
        shift_d    = start_l_s;
        bit_cnt_d  = CW'(DATA_W);
        dac_d      = 1'b0;
      end else if (state_q != ST_RUN) begin
        state_d = ST_SYNC;
        dac_d   = 1'b0;
      end else if (right_start_s) begin
        shift_d   = hold_r_q;
        bit_cnt_d = CW'(DATA_W);
        dac_d     = 1'b0;
      end else if (bit_cnt_q != {CW{1'b0}}) begin
        dac_d     = shift_q[DATA_W-1];
        shift_d   = {shift_q[DATA_W-2:0], 1'b0};
        bit_cnt_d = bit_cnt_q - CW'(1);
      end else begin
        dac_d = 1'b0;
      end
    end else begin
      state_d = state_q;
    end
  end

  // FSM state register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_SYNC;
    end else begin
      state_q <= state_d;
    end
  end

  // Serializer datapath and registered outputs.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      lr_prev_q  <= 1'b1;
      hold_l_q   <= {DATA_W{1'b0}};
      hold_r_q   <= {DATA_W{1'b0}};
      shift_q    <= {DATA_W{1'b0}};
      bit_cnt_q  <= {CW{1'b0}};
      dac_q      <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      lr_prev_q  <= lr_prev_d;
      hold_l_q   <= hold_l_d;
      hold_r_q   <= hold_r_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      dac_q      <= dac_d;
      underrun_q <= underrun_d;
    end
  end

endmodule

// File: tb/tb_i2s_transmit.sv
`timescale 1ns/1ps
// tb_i2s_transmit: table-driven frame vectors plus hand-written sequences
// for backpressure, reset mid-word / start-up and short half-frames.
// BCLK = CLK/16 is generated by the bench; LRCK changes on BCLK falls.
module tb_i2s_transmit;

  localparam int DW = 16;

  logic          CLK = 1'b0;
  logic          RESET_N = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_left = 16'h0000;
  logic [DW-1:0] in_right = 16'h0000;
  logic          AUD_BCLK = 1'b1;
  logic          AUD_DACLRCK = 1'b1;
  logic          AUD_DACDAT;
  logic          underrun;

  int errors = 0;
  int checks = 0;
  int uf_cnt = 0;

  typedef struct {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
    bit            push;
    logic [DW-1:0] el;
    logic [DW-1:0] er;
    int            euf;
  } vec_t;

  vec_t tbl [6];

  i2s_transmit dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_left     (in_left),
    .in_right    (in_right),
    .AUD_BCLK    (AUD_BCLK),
    .AUD_DACLRCK (AUD_DACLRCK),
    .AUD_DACDAT  (AUD_DACDAT),
    .underrun    (underrun)
  );

  always #10 CLK = ~CLK;

  // Count underrun pulses, sampled away from the active edge.
  always @(negedge CLK) begin
    if (underrun === 1'b1) uf_cnt++;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected serial pattern for one half-frame of n BCLKs carrying word w:
  // delay slot, then MSB-first bits, then zero padding.
  function automatic logic [31:0] exp_half(input logic [DW-1:0] w, input int n);
    logic [31:0] v;
    logic        b;
    v = 32'h0;
    for (int i = 0; i < n; i++) begin
      if (i >= 1 && i <= DW) b = w[DW-i];
      else b = 1'b0;
      v = {v[30:0], b};
    end
    return v;
  endfunction

  // Run n BCLK periods with LRCK = lr and capture DACDAT late in each high phase.
  task automatic half(input logic lr, input int n, output logic [31:0] cap);
    cap = 32'h0;
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      AUD_BCLK = 1'b0;
      AUD_DACLRCK = lr;
      #160;
      AUD_BCLK = 1'b1;
      #140;
      cap = {cap[30:0], AUD_DACDAT};
    end
  endtask

  task automatic frame(input logic [DW-1:0] el, input logic [DW-1:0] er,
                       input int n, input int euf, input string tag);
    logic [31:0] cl, cr;
    int u0;
    u0 = uf_cnt;
    half(1'b0, n, cl);
    half(1'b1, n, cr);
    chk({tag, "_left"}, cl, exp_half(el, n));
    chk({tag, "_right"}, cr, exp_half(er, n));
    chk({tag, "_underrun"}, 32'(uf_cnt - u0), 32'(euf));
  endtask

  task automatic push_pair(input logic [DW-1:0] l, input logic [DW-1:0] r);
    bit ok;
    ok = 1'b0;
    in_left = l;
    in_right = r;
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge CLK);
      if (in_ready) begin
        @(posedge CLK);
        ok = 1'b1;
      end
    end
    #1;
    in_valid = 1'b0;
    chk("push_accept", {31'h0, ok}, 32'h1);
  endtask

  initial begin
    logic [31:0] cap;
    int acc;
    logic rdy;

    tbl[0] = '{16'hA5C3, 16'h0F0F, 1'b1, 16'hA5C3, 16'h0F0F, 0};
`ifdef I2S_TX_REPEAT_EN
    tbl[1] = '{16'h0000, 16'h0000, 1'b0, 16'hA5C3, 16'h0F0F, 1};
`else
    tbl[1] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1};
`endif
    tbl[2] = '{16'h8001, 16'h7FFE, 1'b1, 16'h8001, 16'h7FFE, 0};
    tbl[3] = '{16'hFFFF, 16'h0000, 1'b1, 16'hFFFF, 16'h0000, 0};
    tbl[4] = '{16'h0001, 16'h8000, 1'b1, 16'h0001, 16'h8000, 0};
`ifdef I2S_TX_REPEAT_EN
    tbl[5] = '{16'h0000, 16'h0000, 1'b0, 16'h0001, 16'h8000, 1};
`else
    tbl[5] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1};
`endif

    // Reset state.
    repeat (3) @(negedge CLK);
    chk("rst_dacdat", {31'h0, AUD_DACDAT}, 32'h0);
    chk("rst_underrun", {31'h0, underrun}, 32'h0);
    chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
    RESET_N = 1'b1;

    // A right half-frame while unsynchronized must stay silent.
    half(1'b1, 32, cap);
    chk("sync_silent", cap, 32'h0);

    // Table-driven frames.
    for (int k = 0; k < 6; k++) begin
      if (tbl[k].push) push_pair(tbl[k].l, tbl[k].r);
      frame(tbl[k].el, tbl[k].er, 32, tbl[k].euf, $sformatf("vec%0d", k));
    end

    // Backpressure: BCLK idle, in_valid held high.
    acc = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_left = 16'h1000 + 16'(acc + 1);
      in_right = 16'h2000 + 16'(acc + 1);
      @(negedge CLK);
      rdy = in_ready;
      @(posedge CLK);
      #1;
      if (rdy) acc++;
    end
    in_valid = 1'b0;
    chk("bp_accepted", 32'(acc), 32'd4);
    @(negedge CLK);
    chk("bp_ready_low", {31'h0, in_ready}, 32'h0);
    for (int k = 1; k <= 4; k++) begin
      frame(16'h1000 + 16'(k), 16'h2000 + 16'(k), 32, 0, $sformatf("bp%0d", k));
    end
`ifdef I2S_TX_REPEAT_EN
    frame(16'h1004, 16'h2004, 32, 1, "bp_drain");
`else
    frame(16'h0000, 16'h0000, 32, 1, "bp_drain");
`endif

    // Reset mid-word with one pair still queued.
    push_pair(16'hFFFF, 16'hFFFF);
    push_pair(16'h1357, 16'h2468);
    half(1'b0, 6, cap);
    chk("midword_bits", cap, exp_half(16'hFFFF, 6));
    #5;
    RESET_N = 1'b0;
    #1;
    chk("midrst_dacdat", {31'h0, AUD_DACDAT}, 32'h0);
    chk("midrst_underrun", {31'h0, underrun}, 32'h0);
    chk("midrst_in_ready", {31'h0, in_ready}, 32'h1);
    AUD_DACLRCK = 1'b1;
    repeat (3) @(negedge CLK);
    RESET_N = 1'b1;

    // Start-up with LRCK high mid-frame, then confirm the FIFO was cleared.
    half(1'b1, 20, cap);
    chk("startup_silent", cap, 32'h0);
    frame(16'h0000, 16'h0000, 32, 1, "post_rst_empty");
    push_pair(16'h1234, 16'h5678);
    frame(16'h1234, 16'h5678, 32, 0, "post_rst_first");

    // Short half-frames: 8 BCLKs carry only the 7 MSBs.
    push_pair(16'hA5C3, 16'h0F0F);
    push_pair(16'h1234, 16'hABCD);
    frame(16'hA5C3, 16'h0F0F, 8, 0, "short1");
    frame(16'h1234, 16'hABCD, 8, 0, "short2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
